id_ex_stage: RTL and testbench

//  ID->EX pipeline register of the 5-stage RV32I core with integrated load-use hazard detection.
//  It captures the register-file read data, immediate, PC and decoded control bits.
//  On a load-use hazard it inserts a bubble and stalls IF/ID.
//  On flush it squashes the instruction; on downstream hold it freezes.
//  Two saturating event counters record bubbles and flushes for performance debug.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_if.sv | 64 ++++++
 rtl/id_ex_stage_hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 119 +++++++++++
 tb/tb_id_ex_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX pipeline constants: default widths, register x0 index, control bundle layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// The control bundle is opaque to the ID/EX register; the field positions here are
// for the EX/MEM/WB consumers that unpack it.
package id_ex_stage_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Control bundle layout: [3:0] ALU op, [4] ALU A from PC, [5] ALU B from imm,
    // [7:6] WB source select.
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_SEL_A_PC   = 4;
    localparam int CTRL_SEL_B_IMM  = 5;
    localparam int CTRL_WB_SEL_LSB = 6;
    localparam int CTRL_WB_SEL_W   = 2;

    // A bubble is all-zero in every ex_* field, valid and write enables included.
    localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID instruction in, registered EX copy, stall and counters out.
// Latency: n/a (wiring only).
// Backpressure: hold_i freezes the stage; stall_o freezes PC and IF/ID.
//
// master: driven by the ID side / environment; slave: the id_ex_stage register.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              hold_i;
    logic              flush_i;
    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i;
    logic [4:0]        id_rs1_i;
    logic [4:0]        id_rs2_i;
    logic [4:0]        id_rd_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [XLEN-1:0]   id_rdata1_i;
    logic [XLEN-1:0]   id_rdata2_i;
    logic [XLEN-1:0]   id_imm_i;
    logic              id_reg_write_i;
    logic              id_mem_read_i;
    logic              id_mem_write_i;
    logic [CTRL_W-1:0] id_ctrl_i;

    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [4:0]        ex_rs1_o;
    logic [4:0]        ex_rs2_o;
    logic [4:0]        ex_rd_o;
    logic [XLEN-1:0]   ex_rdata1_o;
    logic [XLEN-1:0]   ex_rdata2_o;
    logic [XLEN-1:0]   ex_imm_o;
    logic              ex_reg_write_o;
    logic              ex_mem_read_o;
    logic              ex_mem_write_o;
    logic [CTRL_W-1:0] ex_ctrl_o;

    logic              stall_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_use_rs1_i, id_use_rs2_i, id_rdata1_i, id_rdata2_i, id_imm_i,
               id_reg_write_i, id_mem_read_i, id_mem_write_i, id_ctrl_i,
        input  ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rdata1_o, ex_rdata2_o,
               ex_imm_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_ctrl_o,
               stall_o, bubble_cnt_o, flush_cnt_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_use_rs1_i, id_use_rs2_i, id_rdata1_i, id_rdata2_i, id_imm_i,
               id_reg_write_i, id_mem_read_i, id_mem_write_i, id_ctrl_i,
        output ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rdata1_o, ex_rdata2_o,
               ex_imm_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_ctrl_o,
               stall_o, bubble_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard comparator: EX holds a load whose rd is a source of the ID instruction.
// Latency: combinational.
// Backpressure: none; load_use is consumed by the stall/bubble logic.
//
// Ports: ex_valid/ex_mem_read/ex_rd describe the instruction in EX; id_* describe the
// instruction in ID. A load to x0 never hazards since x0 always reads zero.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic       id_use_rs1,
    input  logic [4:0] id_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rs2,
    output logic       load_use
);
    always_comb begin
        load_use = ex_valid & ex_mem_read & (ex_rd != REG_X0) & id_valid &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion and bubble/flush event counters.
// Latency: 1 cycle ID to EX.
// Backpressure: hold_i freezes all state (flush ignored); stall_o = hold_i | (load_use & ~flush_i).
//
// Ports: clk, rst_n (async active-low) plus bus (id_ex_stage_if.slave) carrying the ID
// instruction, hold/flush, the registered ex_* copy, stall_o and the saturating counters.
// No RF bypass: the register file writes on negedge, so WB data is already in id_rdata*.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [XLEN-1:0]   ex_rdata1;
    logic [XLEN-1:0]   ex_rdata2;
    logic [XLEN-1:0]   ex_imm;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              load_use;

    hazard_detect u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (bus.id_valid_i),
        .id_use_rs1  (bus.id_use_rs1_i),
        .id_rs1      (bus.id_rs1_i),
        .id_use_rs2  (bus.id_use_rs2_i),
        .id_rs2      (bus.id_rs2_i),
        .load_use    (load_use)
    );

    // A flush bubbles the stage anyway, so a coincident load-use must not stall fetch.
    assign bus.stall_o = bus.hold_i | (load_use & ~bus.flush_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= BUBBLE_BIT;
            ex_pc        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rdata1    <= '0;
            ex_rdata2    <= '0;
            ex_imm       <= '0;
            ex_reg_write <= BUBBLE_BIT;
            ex_mem_read  <= BUBBLE_BIT;
            ex_mem_write <= BUBBLE_BIT;
            ex_ctrl      <= '0;
            bubble_cnt   <= '0;
            flush_cnt    <= '0;
        end else if (bus.hold_i) begin
            // Downstream busy: everything, counters included, keeps its value.
        end else if (bus.flush_i || load_use) begin
            ex_valid     <= BUBBLE_BIT;
            ex_pc        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rdata1    <= '0;
            ex_rdata2    <= '0;
            ex_imm       <= '0;
            ex_reg_write <= BUBBLE_BIT;
            ex_mem_read  <= BUBBLE_BIT;
            ex_mem_write <= BUBBLE_BIT;
            ex_ctrl      <= '0;
            if (bus.flush_i) begin
                // Only squashing a real instruction counts as a flush event.
                if (bus.id_valid_i && (flush_cnt != '1))
                    flush_cnt <= flush_cnt + 1'b1;
            end else if (bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end else begin
            ex_valid     <= bus.id_valid_i;
            ex_pc        <= bus.id_pc_i;
            ex_rs1       <= bus.id_rs1_i;
            ex_rs2       <= bus.id_rs2_i;
            ex_rd        <= bus.id_rd_i;
            ex_rdata1    <= bus.id_rdata1_i;
            ex_rdata2    <= bus.id_rdata2_i;
            ex_imm       <= bus.id_imm_i;
            // Writes to x0 are dropped here so EX/MEM/WB and forwarding never see them.
            ex_reg_write <= bus.id_reg_write_i & bus.id_valid_i & (bus.id_rd_i != REG_X0);
            ex_mem_read  <= bus.id_mem_read_i & bus.id_valid_i;
            ex_mem_write <= bus.id_mem_write_i & bus.id_valid_i;
            ex_ctrl      <= bus.id_ctrl_i;
        end
    end

    assign bus.ex_valid_o     = ex_valid;
    assign bus.ex_pc_o        = ex_pc;
    assign bus.ex_rs1_o       = ex_rs1;
    assign bus.ex_rs2_o       = ex_rs2;
    assign bus.ex_rd_o        = ex_rd;
    assign bus.ex_rdata1_o    = ex_rdata1;
    assign bus.ex_rdata2_o    = ex_rdata2;
    assign bus.ex_imm_o       = ex_imm;
    assign bus.ex_reg_write_o = ex_reg_write;
    assign bus.ex_mem_read_o  = ex_mem_read;
    assign bus.ex_mem_write_o = ex_mem_write;
    assign bus.ex_ctrl_o      = ex_ctrl;
    assign bus.bubble_cnt_o   = bubble_cnt;
    assign bus.flush_cnt_o    = flush_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use, x0, flush priority,
// hold freeze, counter saturation (counters built 4 bits wide so all-ones is reachable).
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                            input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic rw, input logic mr,
                            input logic mw, input logic [7:0] ctrl);
        bus.id_valid_i     = v;
        bus.id_pc_i        = pc;
        bus.id_rs1_i       = rs1;
        bus.id_rs2_i       = rs2;
        bus.id_rd_i        = rd;
        bus.id_use_rs1_i   = u1;
        bus.id_use_rs2_i   = u2;
        bus.id_rdata1_i    = d1;
        bus.id_rdata2_i    = d2;
        bus.id_imm_i       = imm;
        bus.id_reg_write_i = rw;
        bus.id_mem_read_i  = mr;
        bus.id_mem_write_i = mw;
        bus.id_ctrl_i      = ctrl;
    endtask

    // lw x7, 0(x2)
    task automatic drive_lw_x7(input logic [31:0] pc);
        drive_id(1'b1, pc, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0,
                 1'b1, 1'b1, 1'b0, 8'h01);
    endtask

    // add x8, x7, x1
    task automatic drive_add_x8(input logic [31:0] pc);
        drive_id(1'b1, pc, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 32'h7777, 32'h1111, 32'h0,
                 1'b1, 1'b0, 1'b0, 8'h02);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        drive_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 8'h0);
        #1;
        chk("rst_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("rst_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Pass-through
        drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678,
                 32'h10, 1'b1, 1'b0, 1'b0, 8'hA5);
        #1;
        chk("pt_stall", 64'(bus.stall_o), 64'd0);
        step();
        chk("pt_valid", 64'(bus.ex_valid_o), 64'd1);
        chk("pt_pc", 64'(bus.ex_pc_o), 64'h100);
        chk("pt_rdata1", 64'(bus.ex_rdata1_o), 64'hDEAD_BEEF);
        chk("pt_rdata2", 64'(bus.ex_rdata2_o), 64'h1234_5678);
        chk("pt_rd", 64'(bus.ex_rd_o), 64'd5);
        chk("pt_reg_write", 64'(bus.ex_reg_write_o), 64'd1);
        chk("pt_imm", 64'(bus.ex_imm_o), 64'h10);
        chk("pt_ctrl", 64'(bus.ex_ctrl_o), 64'hA5);

        // Load-use: lw x7 in EX, add x8,x7,x1 in ID
        drive_lw_x7(32'h104);
        step();
        chk("lu_load_mem_read", 64'(bus.ex_mem_read_o), 64'd1);
        drive_add_x8(32'h108);
        #1;
        chk("lu_stall", 64'(bus.stall_o), 64'd1);
        step();
        chk("lu_bubble_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("lu_bubble_reg_write", 64'(bus.ex_reg_write_o), 64'd0);
        chk("lu_bubble_pc", 64'(bus.ex_pc_o), 64'd0);
        chk("lu_bubble_rdata1", 64'(bus.ex_rdata1_o), 64'd0);
        chk("lu_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);
        chk("lu_stall_released", 64'(bus.stall_o), 64'd0);
        step();
        chk("lu_add_valid", 64'(bus.ex_valid_o), 64'd1);
        chk("lu_add_pc", 64'(bus.ex_pc_o), 64'h108);
        chk("lu_add_rd", 64'(bus.ex_rd_o), 64'd8);
        chk("lu_bubble_cnt_once", 64'(bus.bubble_cnt_o), 64'd1);

        // x0 load: lw x0 reaches EX with reg_write gated off
        drive_id(1'b1, 32'h10C, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 1'b0, 8'h01);
        step();
        chk("x0_reg_write_gated", 64'(bus.ex_reg_write_o), 64'd0);
        chk("x0_mem_read", 64'(bus.ex_mem_read_o), 64'd1);
        drive_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b0, 8'h02);
        #1;
        chk("x0_no_stall", 64'(bus.stall_o), 64'd0);
        step();
        chk("x0_next_pc", 64'(bus.ex_pc_o), 64'h110);
        chk("x0_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);

        // Flush beats load-use in the same cycle
        drive_lw_x7(32'h114);
        step();
        drive_add_x8(32'h118);
        bus.flush_i = 1'b1;
        #1;
        chk("fl_stall", 64'(bus.stall_o), 64'd0);
        step();
        bus.flush_i = 1'b0;
        chk("fl_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("fl_pc", 64'(bus.ex_pc_o), 64'd0);
        chk("fl_flush_cnt", 64'(bus.flush_cnt_o), 64'd1);
        chk("fl_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);

        // Hold with flush asserted freezes everything
        drive_id(1'b1, 32'h200, 5'd4, 5'd5, 5'd3, 1'b1, 1'b1, 32'hCAFE_0001, 32'h2,
                 32'h3, 1'b1, 1'b0, 1'b1, 8'h3C);
        step();
        chk("hd_pre_pc", 64'(bus.ex_pc_o), 64'h200);
        chk("hd_pre_mem_write", 64'(bus.ex_mem_write_o), 64'd1);
        bus.hold_i  = 1'b1;
        bus.flush_i = 1'b1;
        drive_id(1'b1, 32'h300, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7,
                 1'b1, 1'b1, 1'b0, 8'hFF);
        #1;
        chk("hd_stall", 64'(bus.stall_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hd_pc", 64'(bus.ex_pc_o), 64'h200);
            chk("hd_valid", 64'(bus.ex_valid_o), 64'd1);
            chk("hd_rdata1", 64'(bus.ex_rdata1_o), 64'hCAFE_0001);
            chk("hd_flush_cnt", 64'(bus.flush_cnt_o), 64'd1);
            chk("hd_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd1);
        end
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;

        // Reset asserted mid-cycle clears state without waiting for an edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(bus.ex_valid_o), 64'd0);
        chk("mr_pc", 64'(bus.ex_pc_o), 64'd0);
        chk("mr_rdata1", 64'(bus.ex_rdata1_o), 64'd0);
        chk("mr_mem_write", 64'(bus.ex_mem_write_o), 64'd0);
        chk("mr_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
        chk("mr_flush_cnt", 64'(bus.flush_cnt_o), 64'd0);
        chk("mr_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd0);
        step();
        chk("mr_held_pc", 64'(bus.ex_pc_o), 64'd0);
        rst_n = 1'b1;

        // Bubble counter saturates at all-ones (4'hF) and does not wrap
        for (int i = 0; i < 17; i++) begin
            drive_lw_x7(32'h400);
            step();
            drive_add_x8(32'h404);
            step();
            step();
            if (i == 14) chk("sat_reach", 64'(bus.bubble_cnt_o), 64'hF);
        end
        chk("sat_hold", 64'(bus.bubble_cnt_o), 64'hF);
        chk("sat_flush_cnt", 64'(bus.flush_cnt_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
